// File: rtl/occupancy_pkg.sv
// Shared types and map geometry for the occupancy-grid RAM arbiter.
package occupancy_pkg;

  localparam int unsigned MAP_WIDTH  = 256;
  localparam int unsigned MAP_HEIGHT = 128;

  typedef enum logic {CLEAR, SERVE} arb_state_t;

  typedef enum logic {REQ_UPDATE, REQ_MATCH} requester_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant logic; round-robin pointer only when OCC_ARB_ROUND_ROBIN_EN is defined,
// otherwise fixed priority with the update engine always winning.
module rr_arbiter2
  import occupancy_pkg::*;
(
`ifdef OCC_ARB_ROUND_ROBIN_EN
  input  logic clock,
  input  logic reset,
`endif
  input  logic en,
  input  logic req_upd,
  input  logic req_mat,
  output logic gnt_upd,
  output logic gnt_mat
);

`ifdef OCC_ARB_ROUND_ROBIN_EN
  requester_t ptr_q, ptr_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= REQ_UPDATE;
    else       ptr_q <= ptr_d;
  end

  // Pointer hands priority to the loser, and moves only on a granted contention.
  always_comb begin
    gnt_upd = en & req_upd & (~req_mat | (ptr_q == REQ_UPDATE));
    gnt_mat = en & req_mat & ~gnt_upd;
    ptr_d   = ptr_q;
    if (en && req_upd && req_mat)
      ptr_d = (ptr_q == REQ_UPDATE) ? REQ_MATCH : REQ_UPDATE;
  end
`else
  always_comb begin
    gnt_upd = en & req_upd;
    gnt_mat = en & req_mat & ~req_upd;
  end
`endif

endmodule

// File: rtl/occupancy_map_arbiter.sv
// Single-port occupancy-grid RAM arbiter with automatic clear sequencer.
// Build option: OCC_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed update priority.
module occupancy_map_arbiter
  import occupancy_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = $clog2(MAP_WIDTH * MAP_HEIGHT),
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_start,
  output logic                  clear_busy,
  input  logic                  upd_req,
  input  logic                  upd_we,
  input  logic [ADDR_WIDTH-1:0] upd_addr,
  input  logic [DATA_WIDTH-1:0] upd_wdata,
  output logic                  upd_gnt,
  output logic                  upd_rvalid,
  output logic [DATA_WIDTH-1:0] upd_rdata,
  input  logic                  mat_req,
  input  logic [ADDR_WIDTH-1:0] mat_addr,
  output logic                  mat_gnt,
  output logic                  mat_rvalid,
  output logic [DATA_WIDTH-1:0] mat_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  rd_pend_q, rd_pend_d;
  requester_t            rd_tag_q, rd_tag_d;
  logic                  arb_en;
  logic                  gnt_u, gnt_m;

  // A clear_start seen in SERVE blocks all grants for that cycle.
  always_comb begin
    arb_en = (state_q == SERVE) && !clear_start;
  end

  rr_arbiter2 u_arb (
`ifdef OCC_ARB_ROUND_ROBIN_EN
    .clock   (clock),
    .reset   (reset),
`endif
    .en      (arb_en),
    .req_upd (upd_req),
    .req_mat (mat_req),
    .gnt_upd (gnt_u),
    .gnt_mat (gnt_m)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_tag_q    <= REQ_UPDATE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
      rd_pend_q   <= rd_pend_d;
      rd_tag_q    <= rd_tag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_pend_d = (gnt_u & ~upd_we) | gnt_m;
    rd_tag_d  = gnt_m ? REQ_MATCH : REQ_UPDATE;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = SERVE;
      end
      SERVE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // RAM port is combinational from the grant; address and data hold when idle.
  // Reset is folded in so the port is quiet while reset is asserted.
  always_comb begin
    clear_busy = (state_q == CLEAR);
    upd_gnt    = gnt_u;
    mat_gnt    = gnt_m;
    mem_we     = 1'b0;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = INIT_VALUE;
    end else if (gnt_u) begin
      mem_we    = upd_we;
      mem_addr  = upd_addr;
      mem_wdata = upd_wdata;
    end else if (gnt_m) begin
      mem_addr  = mat_addr;
    end
    if (reset) begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
    upd_rvalid = rd_pend_q && (rd_tag_q == REQ_UPDATE);
    mat_rvalid = rd_pend_q && (rd_tag_q == REQ_MATCH);
    upd_rdata  = upd_rvalid ? mem_rdata : '0;
    mat_rdata  = mat_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_occupancy_map_arbiter.sv
// Scoreboard bench for occupancy_map_arbiter on a 16-cell map with a behavioural RAM.
module tb_occupancy_map_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned CELLS = 1 << AW;
  localparam logic [DW-1:0] INIT = 8'h3C;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic          upd_req = 1'b0, upd_we = 1'b0;
  logic [AW-1:0] upd_addr = '0;
  logic [DW-1:0] upd_wdata = '0;
  logic          upd_gnt, upd_rvalid;
  logic [DW-1:0] upd_rdata;
  logic          mat_req = 1'b0;
  logic [AW-1:0] mat_addr = '0;
  logic          mat_gnt, mat_rvalid;
  logic [DW-1:0] mat_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  occupancy_map_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(INIT)) dut (
    .clock(clock), .reset(reset), .clear_start(clear_start), .clear_busy(clear_busy),
    .upd_req(upd_req), .upd_we(upd_we), .upd_addr(upd_addr), .upd_wdata(upd_wdata),
    .upd_gnt(upd_gnt), .upd_rvalid(upd_rvalid), .upd_rdata(upd_rdata),
    .mat_req(mat_req), .mat_addr(mat_addr), .mat_gnt(mat_gnt),
    .mat_rvalid(mat_rvalid), .mat_rdata(mat_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM: read data appears one cycle after the address.
  logic [DW-1:0] ram [0:CELLS-1];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit            m_busy = 1'b1;
  int unsigned   m_cnt = 0;
  bit            m_ptr = 1'b0;
  logic [AW-1:0] m_last_addr = '0;
  logic [DW-1:0] ref_map [0:CELLS-1];
  logic [DW-1:0] upd_q[$];
  logic [DW-1:0] mat_q[$];
  bit            upd_acc = 1'b0, mat_acc = 1'b0;

  always @(negedge clock) begin
    logic          eu, em;
    logic [DW-1:0] exp_d;
    upd_acc = upd_gnt;
    mat_acc = mat_gnt;
    if (reset) begin
      chk("rst_busy", clear_busy, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_gnt", {upd_gnt, mat_gnt}, 0);
      chk("rst_rvalid", {upd_rvalid, mat_rvalid}, 0);
      chk("rst_rdata", {upd_rdata, mat_rdata}, 0);
      m_busy = 1'b1; m_cnt = 0; m_ptr = 1'b0; m_last_addr = '0;
      upd_q.delete(); mat_q.delete();
    end else begin
      chk("upd_rvalid", upd_rvalid, upd_q.size() != 0);
      if (upd_rvalid && upd_q.size() != 0) begin
        exp_d = upd_q.pop_front();
        chk("upd_rdata", upd_rdata, exp_d);
      end
      chk("mat_rvalid", mat_rvalid, mat_q.size() != 0);
      if (mat_rvalid && mat_q.size() != 0) begin
        exp_d = mat_q.pop_front();
        chk("mat_rdata", mat_rdata, exp_d);
      end
      chk("clear_busy", clear_busy, m_busy);
      if (m_busy) begin
        chk("clr_gnt", {upd_gnt, mat_gnt}, 0);
        chk("clr_we", mem_we, 1);
        chk("clr_addr", mem_addr, m_cnt);
        chk("clr_wdata", mem_wdata, INIT);
        ref_map[m_cnt] = INIT;
        m_last_addr = AW'(m_cnt);
        m_cnt++;
        if (m_cnt == CELLS) begin m_busy = 1'b0; m_cnt = 0; end
      end else if (clear_start) begin
        chk("cs_gnt", {upd_gnt, mat_gnt}, 0);
        chk("cs_we", mem_we, 0);
        chk("cs_addr_hold", mem_addr, m_last_addr);
        m_busy = 1'b1; m_cnt = 0;
      end else begin
        eu = upd_req && (!mat_req || !m_ptr);
        em = mat_req && !eu;
        chk("upd_gnt", upd_gnt, eu);
        chk("mat_gnt", mat_gnt, em);
        if (eu) begin
          chk("upd_mem_we", mem_we, upd_we);
          chk("upd_mem_addr", mem_addr, upd_addr);
          if (upd_we) begin
            chk("upd_mem_wdata", mem_wdata, upd_wdata);
            ref_map[upd_addr] = upd_wdata;
          end else upd_q.push_back(ref_map[upd_addr]);
          m_last_addr = upd_addr;
        end else if (em) begin
          chk("mat_mem_we", mem_we, 0);
          chk("mat_mem_addr", mem_addr, mat_addr);
          mat_q.push_back(ref_map[mat_addr]);
          m_last_addr = mat_addr;
        end else begin
          chk("idle_we", mem_we, 0);
          chk("idle_addr_hold", mem_addr, m_last_addr);
        end
`ifdef OCC_ARB_ROUND_ROBIN_EN
        if (upd_req && mat_req) m_ptr = ~m_ptr;
`endif
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (clear_busy && n < bound) begin step(); n++; end
    chk("idle_timeout", clear_busy, 0);
  endtask

  task automatic upd_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    upd_req = 1'b1; upd_we = we; upd_addr = a; upd_wdata = d;
    do begin step(); n++; end while (!upd_acc && n < 60);
    chk("upd_txn_timeout", upd_acc, 1);
    upd_req = 1'b0;
  endtask

  task automatic mat_txn(input logic [AW-1:0] a);
    int n = 0;
    mat_req = 1'b1; mat_addr = a;
    do begin step(); n++; end while (!mat_acc && n < 60);
    chk("mat_txn_timeout", mat_acc, 1);
    mat_req = 1'b0;
  endtask

  initial begin
    #1;
    repeat (3) step();
    reset = 1'b0;
    wait_idle(40);

    // Write then read back through the matcher
    upd_txn(1'b1, 4'd5, 8'h7F);
    mat_txn(4'd5);
    repeat (2) step();

    // Both requesters reading under contention
    upd_req = 1'b1; upd_we = 1'b0; upd_addr = 4'd5;
    mat_req = 1'b1; mat_addr = 4'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      if (upd_acc) upd_addr = AW'($urandom_range(0, CELLS - 1));
      if (mat_acc) mat_addr = AW'($urandom_range(0, CELLS - 1));
    end
    upd_req = 1'b0;
    mat_txn(mat_addr);
    repeat (2) step();

    // clear_start collides with a pending matcher read
    mat_req = 1'b1; mat_addr = 4'd5; clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    mat_txn(4'd5);
    repeat (2) step();

    // Reset in the middle of a clear
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_idle(40);

    // clear_start pulsed while already clearing is ignored
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (5) step();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    wait_idle(40);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 800; i++) begin
      if (!upd_req || upd_acc) begin
        upd_req   = ($urandom_range(0, 2) != 0);
        upd_we    = $urandom_range(0, 1) == 1;
        upd_addr  = AW'($urandom_range(0, CELLS - 1));
        upd_wdata = DW'($urandom_range(0, 255));
      end
      if (!mat_req || mat_acc) begin
        mat_req  = ($urandom_range(0, 2) != 0);
        mat_addr = AW'($urandom_range(0, CELLS - 1));
      end
      clear_start = ($urandom_range(0, 79) == 0);
      step();
    end
    clear_start = 1'b0;
    upd_req = 1'b0; mat_req = 1'b0;
    wait_idle(40);
    repeat (3) step();
    chk("upd_q_drained", upd_q.size(), 0);
    chk("mat_q_drained", mat_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/occupancy_map_arbiter.md
# occupancy_map_arbiter

Shares the single-port occupancy-grid RAM (256×128 cells) between the map-update engine (read/write) and the scan-matcher (read-only). Owns a clear sequencer that fills every cell with the initial value automatically after reset and on request. Sits between the requesters and the RAM inside the occupancy module's data flow.

## Interface
- ADDR_WIDTH, 15, cell address width; the map holds 2^ADDR_WIDTH cells (256×128)
- DATA_WIDTH, 8, cell (log-odds) width
- INIT_VALUE, 0, value written to every cell by a clear
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- clear_start  in  1  one-cycle pulse; starts a full-map clear when idle
- clear_busy  out  1  high while a clear is in progress
- upd_req / upd_we  in  1 / 1  update request, write enable
- upd_addr / upd_wdata  in  ADDR_WIDTH / DATA_WIDTH  update address, write data
- upd_gnt  out  1  update request accepted this cycle
- upd_rvalid / upd_rdata  out  1 / DATA_WIDTH  update read response
- mat_req / mat_addr  in  1 / ADDR_WIDTH  matcher read request, address
- mat_gnt  out  1  matcher request accepted this cycle
- mat_rvalid / mat_rdata  out  1 / DATA_WIDTH  matcher read response
- mem_addr / mem_we / mem_wdata  out  ADDR_WIDTH / 1 / DATA_WIDTH  RAM port
- mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after address

## Operation
- States: CLEAR, SERVE. Reset forces CLEAR with clear counter = 0.
- CLEAR: each cycle mem_we=1, mem_addr=counter, mem_wdata=INIT_VALUE, counter+1; after writing address 2^ADDR_WIDTH−1, go to SERVE. Both gnt low throughout.
- SERVE: clear_start=1 → CLEAR, counter=0; that cycle grants nothing. Otherwise arbitrate.
- Arbitration (combinational gnt): only one requester → granted. Both → the one indicated by the priority pointer; the pointer then moves to the other requester. The pointer moves only on contention.
- Granted request drives mem_addr/mem_we/mem_wdata the same cycle; matcher always reads (mem_we=0).
- Read grant records a requester tag; next cycle the matching rvalid=1 and rdata=mem_rdata. Writes produce no rvalid.
- No grant: mem_we=0, mem_addr holds the last value.
- Requests are level: a requester holds req/addr/data until it sees gnt.

## Timing
- Reset values: clear_busy=1, mem_we=0, mem_addr=0, mem_wdata=0, all gnt and rvalid=0, rdata=0, priority pointer=update.
- Clear takes exactly 2^ADDR_WIDTH cycles (32768 at default). clear_busy falls the cycle after the last write; the first grant is possible that same cycle.
- Read latency: gnt in cycle N → rvalid in N+1. Back-to-back reads at one grant per cycle.
- clear_start while clear_busy is ignored. clear_start together with req → clear wins; the req is not granted and stays pending.
- A read granted in the last SERVE cycle before CLEAR still returns its rvalid in the next cycle.
- Reset during a clear restarts it from address 0 and drops any pending rvalid.

## Configuration
- OCC_ARB_ROUND_ROBIN_EN defined: round-robin pointer as described.
- Not defined: fixed priority, update always beats matcher; pointer logic is absent.

## Structure
- Shared package occupancy_pkg holds:
  - MAP_WIDTH=256, MAP_HEIGHT=128
  - the arb_state_t enum {CLEAR, SERVE}
  - the requester_t enum {REQ_UPDATE, REQ_MATCH}
- One sub-module, rr_arbiter2: two-input grant logic plus pointer register; its pointer is bypassed when the macro is off.

## Test plan
- Reset, ADDR_WIDTH=4 → 16 writes of INIT_VALUE to addresses 0..15, then clear_busy=0 at cycle 16; no gnt before that.
- Update write addr 5, data 0x7F, then matcher read addr 5 → mat_gnt, then one cycle later mat_rvalid=1, mat_rdata=0x7F.
- Both requesting reads for 4 cycles with round-robin on → grants alternate upd, mat, upd, mat. With the macro off → upd on all 4 cycles.
- clear_start during a matcher request → no grant. The RAM clears to INIT_VALUE and the pending read is then granted and returns INIT_VALUE.
- Assert reset at clear address 9 → the clear restarts at 0, busy stays high for a full 16 cycles after release.
- clear_start pulsed mid-clear → ignored; clear_busy falls on the original schedule.
